ads8684_ctrl: RTL and testbench

ADS8684_CTRL -- requirements
Module: ads8684_ctrl

---
 rtl/ads8684_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ads8684_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads8684_ctrl.sv
// ---------------------------------------------------------------------------
// ads8684_ctrl
//   Frame controller for an ADS8684-style SAR ADC. Each frame sends a 32-bit
//   word {cmd, 16'h0000} MSB first on sdi while capturing sdo. cmd selects the
//   input channel for the next conversion. The ADC is pipelined, so each frame
//   returns the result commanded by the previous frame. Results are published
//   with the channel they belong to.
//
//   Frame timeline, measured in clk cycles from the edge that samples start:
//     SETUP : SCLK_DIV cycles, csn low, sclk low, sdi = first command bit
//     SHIFT : 64 sclk toggles spaced SCLK_DIV apart (32 full periods)
//     HOLD  : SCLK_DIV cycles, csn low, sclk low
//     GAP   : CSN_HIGH cycles, csn high, start ignored
//   csn is low for 66*SCLK_DIV cycles in total.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      frame request, sampled only while idle
//   chan[1:0]  channel to command, sampled together with start
//   busy       high whenever the controller is not idle
//   data[15:0] last published conversion result
//   data_chan  channel that data belongs to
//   data_valid one-cycle strobe when data/data_chan are updated
//   csn        ADC chip select, active low
//   sclk       ADC serial clock, idles low
//   sdi        command bit to the ADC
//   sdo        result bit from the ADC
// ---------------------------------------------------------------------------
module ads8684_ctrl #(
  parameter int SCLK_DIV = 2,   // sclk half-period in clk cycles, 1..255
  parameter int CSN_HIGH = 4    // csn-high gap between frames, 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  chan,
  output logic        busy,
  output logic [15:0] data,
  output logic [1:0]  data_chan,
  output logic        data_valid,
  output logic        csn,
  output logic        sclk,
  output logic        sdi,
  input  logic        sdo
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CSN_HIGH - 1);
  localparam logic [5:0] EDGE_LAST = 6'd63;  // 64th toggle is the 32nd fall

  logic [2:0]  state;
  logic [7:0]  clk_cnt;    // cycles spent in the current phase
  logic [5:0]  edge_cnt;   // sclk toggles issued so far in SHIFT
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;      // only the leading 16 bits of the frame carry data
  logic [1:0]  cur_chan;   // channel commanded by the frame in flight
  logic [1:0]  prev_chan;  // channel whose result the frame in flight returns
  logic        prev_valid; // a complete frame has been sent since reset

  assign busy = (state != ST_IDLE);
  // tx_sr is zero whenever the block is idle, so sdi idles low for free.
  assign sdi  = tx_sr[31];

  // NOTE: every register below is assigned with <= so all of them update
  // from the same pre-edge values; blocking assignments here would let the
  // order of statements change the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cur_chan   <= '0;
      prev_chan  <= '0;
      prev_valid <= 1'b0;
      csn        <= 1'b1;
      sclk       <= 1'b0;
      data       <= '0;
      data_chan  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt  <= '0;
          edge_cnt <= '0;
          if (start) begin
            cur_chan <= chan;
            // cmd = 16'hC000 | chan << 10, followed by 16 zero bits
            tx_sr    <= {4'b1100, chan, 26'd0};
            csn      <= 1'b0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (clk_cnt == DIV_LAST) begin
            clk_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (clk_cnt == DIV_LAST) begin
            clk_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              // Rising edge: sample sdo. Rises 1..16 occur at even toggle
              // counts below 32 and carry the conversion result.
              if (!edge_cnt[5]) rx_sr <= {rx_sr[14:0], sdo};
            end else begin
              // Falling edge: present the next command bit.
              tx_sr <= {tx_sr[30:0], 1'b0};
            end
            if (edge_cnt == EDGE_LAST) begin
              edge_cnt <= '0;
              state    <= ST_HOLD;
            end else begin
              edge_cnt <= edge_cnt + 6'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          if (clk_cnt == DIV_LAST) begin
            clk_cnt <= '0;
            csn     <= 1'b1;
            state   <= ST_GAP;
            // The result in rx_sr belongs to the previous frame's command;
            // nothing is published until such a frame exists.
            if (prev_valid) begin
              data       <= rx_sr;
              data_chan  <= prev_chan;
              data_valid <= 1'b1;
            end
            prev_chan  <= cur_chan;
            prev_valid <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (clk_cnt == GAP_LAST) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          csn   <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads8684_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ads8684_ctrl
//   Directed bench for ads8684_ctrl. u_dut runs with SCLK_DIV=2/CSN_HIGH=4,
//   u_dut1 with SCLK_DIV=1. A pipelined ADC model per DUT drives sdo; bus
//   monitors measure csn/busy windows, sclk periods and the sdi word.
// ---------------------------------------------------------------------------
module tb_ads8684_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic [1:0]  chan = 2'd0, chan1 = 2'd0;
  logic        busy, busy1;
  logic [15:0] data, data1;
  logic [1:0]  data_chan, data_chan1;
  logic        data_valid, data_valid1;
  logic        csn, csn1, sclk, sclk1, sdi, sdi1;
  logic        sdo, sdo1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ads8684_ctrl #(.SCLK_DIV(2), .CSN_HIGH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .chan(chan), .busy(busy),
    .data(data), .data_chan(data_chan), .data_valid(data_valid),
    .csn(csn), .sclk(sclk), .sdi(sdi), .sdo(sdo)
  );

  ads8684_ctrl #(.SCLK_DIV(1), .CSN_HIGH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .chan(chan1), .busy(busy1),
    .data(data1), .data_chan(data_chan1), .data_valid(data_valid1),
    .csn(csn1), .sclk(sclk1), .sdi(sdi1), .sdo(sdo1)
  );

  // ---------------- ADC model + monitor for u_dut ----------------
  logic [15:0] ain [4];
  logic [15:0] pending = 16'h0;
  logic [31:0] out_sr = 32'h0;
  logic [31:0] sdi_word = 32'h0, last_sdi = 32'h0;
  logic        p_csn = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
  int cyc = 0, csn_falls = 0, fall_cyc = 0;
  int cur_low = 0, cur_rises = 0, cur_min = 999, cur_max = 0, last_rise = -1;
  int last_low = 0, last_rises = 0, last_min = 0, last_max = 0;
  int cur_busy = 0, last_busy = 0;
  int dv_count = 0, dv_lat = 0, dv_run = 0, dv_max_run = 0;
  logic [15:0] dv_data = 16'h0;
  logic [1:0]  dv_chan = 2'd0;

  assign sdo = out_sr[31];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (p_csn && !csn) begin
      csn_falls = csn_falls + 1;
      fall_cyc  = cyc;
      cur_low = 0; cur_rises = 0; cur_min = 999; cur_max = 0; last_rise = -1;
      sdi_word = 32'h0;
      out_sr   = {pending, 16'h0};
    end else if (!csn && p_sclk && !sclk) begin
      out_sr = out_sr << 1;
    end
    if (!csn) cur_low = cur_low + 1;
    if (!csn && sclk && !p_sclk) begin
      cur_rises = cur_rises + 1;
      sdi_word  = {sdi_word[30:0], sdi};
      if (last_rise >= 0) begin
        if (cyc - last_rise < cur_min) cur_min = cyc - last_rise;
        if (cyc - last_rise > cur_max) cur_max = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (!p_csn && csn) begin
      last_low = cur_low; last_rises = cur_rises;
      last_min = cur_min; last_max = cur_max; last_sdi = sdi_word;
      // Only a complete, well-formed command starts a new conversion.
      if (cur_rises == 32 && sdi_word[31:28] == 4'hC)
        pending = ain[sdi_word[27:26]];
    end
    if (!p_busy && busy) cur_busy = 0;
    if (busy) cur_busy = cur_busy + 1;
    if (p_busy && !busy) last_busy = cur_busy;
    if (data_valid) begin
      dv_count = dv_count + 1;
      dv_data  = data;
      dv_chan  = data_chan;
      dv_lat   = cyc - fall_cyc;
      dv_run   = dv_run + 1;
      if (dv_run > dv_max_run) dv_max_run = dv_run;
    end else begin
      dv_run = 0;
    end
    p_csn = csn; p_sclk = sclk; p_busy = busy;
  end

  // ---------------- ADC model + monitor for u_dut1 ----------------
  logic [31:0] out_sr1 = 32'h0;
  logic        p_csn1 = 1'b1, p_sclk1 = 1'b0;
  int min1 = 999, max1 = 0, last_rise1 = -1, dv1_count = 0;
  logic [15:0] dv1_data = 16'h0;

  assign sdo1 = out_sr1[31];

  always @(negedge clk) begin
    if (p_csn1 && !csn1) begin
      out_sr1    = {16'hCAFE, 16'h0};
      last_rise1 = -1;
    end else if (!csn1 && p_sclk1 && !sclk1) begin
      out_sr1 = out_sr1 << 1;
    end
    if (!csn1 && sclk1 && !p_sclk1) begin
      if (last_rise1 >= 0) begin
        if (cyc - last_rise1 < min1) min1 = cyc - last_rise1;
        if (cyc - last_rise1 > max1) max1 = cyc - last_rise1;
      end
      last_rise1 = cyc;
    end
    if (data_valid1) begin
      dv1_count = dv1_count + 1;
      dv1_data  = data1;
    end
    p_csn1 = csn1; p_sclk1 = sclk1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one frame on the selected DUT and wait until it is idle again.
  task automatic do_frame(input bit use_dut1, input logic [1:0] ch);
    bit done = 0;
    @(posedge clk); #1;
    if (use_dut1) begin start1 = 1'b1; chan1 = ch; end
    else          begin start  = 1'b1; chan  = ch; end
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!(use_dut1 ? busy1 : busy)) begin done = 1; break; end
    end
    check("frame_timeout", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int falls0, dv0;
  bit reached;

  initial begin
    ain[0] = 16'hCAFE; ain[1] = 16'h0000; ain[2] = 16'h0000; ain[3] = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_csn",   32'(csn),        32'd1);
    check("rst_sclk",  32'(sclk),       32'd0);
    check("rst_sdi",   32'(sdi),        32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_data",  32'(data),       32'h0);
    check("rst_dchan", 32'(data_chan),  32'd0);
    check("rst_dv",    32'(data_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1 on channel 0: bus timing, no data_valid
    do_frame(0, 2'd0);
    check("f1_no_dv",   32'(dv_count),   32'd0);
    check("f1_rises",   32'(last_rises), 32'd32);
    check("f1_per_min", 32'(last_min),   32'd4);
    check("f1_per_max", 32'(last_max),   32'd4);
    check("f1_csn_low", 32'(last_low),   32'd132);
    check("f1_busy",    32'(last_busy),  32'd136);
    check("f1_sdi",     last_sdi,        32'hC000_0000);
    check("idle_csn",   32'(csn),        32'd1);
    check("idle_sclk",  32'(sclk),       32'd0);

    // Frame 2 on channel 0: returns frame 1's conversion
    do_frame(0, 2'd0);
    check("f2_dv_cnt",  32'(dv_count),   32'd1);
    check("f2_data",    32'(dv_data),    32'hCAFE);
    check("f2_chan",    32'(dv_chan),    32'd0);
    check("f2_dv_1cyc", 32'(dv_max_run), 32'd1);
    check("f2_latency", 32'(dv_lat),     32'd132);
    check("f2_hold",    32'(data),       32'hCAFE);

    // Channel sweep 0,1,2,3,0
    ain[0] = 16'h1111; ain[1] = 16'h2222; ain[2] = 16'h3333; ain[3] = 16'h4444;
    do_frame(0, 2'd0);
    do_frame(0, 2'd1);
    check("sw1_data", 32'(dv_data), 32'h1111);
    check("sw1_chan", 32'(dv_chan), 32'd0);
    check("sw1_sdi",  last_sdi,     32'hC400_0000);
    do_frame(0, 2'd2);
    check("sw2_data", 32'(dv_data), 32'h2222);
    check("sw2_chan", 32'(dv_chan), 32'd1);
    check("sw2_sdi",  last_sdi,     32'hC800_0000);
    do_frame(0, 2'd3);
    check("sw3_data", 32'(dv_data), 32'h3333);
    check("sw3_chan", 32'(dv_chan), 32'd2);
    check("sw3_sdi",  last_sdi,     32'hCC00_0000);
    do_frame(0, 2'd0);
    check("sw4_data", 32'(dv_data), 32'h4444);
    check("sw4_chan", 32'(dv_chan), 32'd3);

    // Start while busy: second request with chan=3 must be dropped
    falls0 = csn_falls;
    @(posedge clk); #1 start = 1'b1; chan = 2'd1;
    @(posedge clk); #1 start = 1'b0;
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cur_low >= 10) begin reached = 1; break; end
    end
    check("bz_reach", 32'(reached), 32'd1);
    @(posedge clk); #1 start = 1'b1; chan = 2'd3;
    @(posedge clk); #1 start = 1'b0; chan = 2'd0;
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin reached = 1; break; end
    end
    check("bz_idle", 32'(reached), 32'd1);
    repeat (40) @(negedge clk);
    check("bz_falls", 32'(csn_falls - falls0), 32'd1);
    check("bz_busy",  32'(busy),               32'd0);
    check("bz_data",  32'(dv_data),            32'h1111);
    do_frame(0, 2'd2);
    check("bz_next_data", 32'(dv_data), 32'h2222);
    check("bz_next_chan", 32'(dv_chan), 32'd1);

    // Reset mid-frame after 12 sclk rises
    @(posedge clk); #1 start = 1'b1; chan = 2'd3;
    @(posedge clk); #1 start = 1'b0;
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cur_rises >= 12) begin reached = 1; break; end
    end
    check("mr_reach", 32'(reached), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("mr_csn",  32'(csn),  32'd1);
    check("mr_sclk", 32'(sclk), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_sdi",  32'(sdi),  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    dv0 = dv_count;
    do_frame(0, 2'd1);
    check("mr_first_no_dv", 32'(dv_count - dv0), 32'd0);
    do_frame(0, 2'd2);
    check("mr_second_dv", 32'(dv_count - dv0), 32'd1);
    check("mr_data",      32'(dv_data),        32'h2222);
    check("mr_chan",      32'(dv_chan),        32'd1);

    // SCLK_DIV=1 instance: two channel-0 frames
    do_frame(1, 2'd0);
    check("d1_no_dv", 32'(dv1_count), 32'd0);
    do_frame(1, 2'd0);
    check("d1_dv",      32'(dv1_count), 32'd1);
    check("d1_per_min", 32'(min1),      32'd2);
    check("d1_per_max", 32'(max1),      32'd2);
    check("d1_data",    32'(dv1_data),  32'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
